// File: rtl/ps2_command_transmitter_if.sv
// Command-side handshake between host logic and the PS/2 host-to-device transmitter.
// The host logic uses the master modport and the transmitter uses the slave modport.
interface ps2_command_transmitter_if;
  logic [7:0] command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  modport master (
    output command,
    output send_command,
    input  busy,
    input  command_was_sent,
    input  error_communication_timed_out
  );

  modport slave (
    input  command,
    input  send_command,
    output busy,
    output command_was_sent,
    output error_communication_timed_out
  );
endinterface

// File: rtl/ps2_command_transmitter.sv
// PS/2 host-to-device command transmitter. It inhibits the bus, issues the start bit,
// shifts out data/parity/stop on device clock falls, then checks the ACK.
module ps2_command_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  ps2_command_transmitter_if.slave cmd_if,
  input  logic                    ps2_clk_in,
  input  logic                    ps2_dat_in,
  output logic                    ps2_clk_oe,
  output logic                    ps2_dat_oe
);

  localparam int MAX_AB     = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CYCLES = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_INHIBIT      = 4'd1,
    ST_REQUEST      = 4'd2,
    ST_WAIT_CLK     = 4'd3,
    ST_SEND         = 4'd4,
    ST_WAIT_ACK     = 4'd5,
    ST_WAIT_RELEASE = 4'd6,
    ST_DONE         = 4'd7,
    ST_ERROR        = 4'd8
  } state_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] value);
    return (value >= 4'd11) ? 4'd11 : value + 4'd1;
  endfunction

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [3:0]         bit_cnt_r, bit_cnt_n;
  logic [7:0]         cmd_r, cmd_n;
  logic               par_r, par_n;
  logic               clk_oe_r, clk_oe_n;
  logic               dat_oe_r, dat_oe_n;
  logic               busy_r, busy_n;
  logic               sent_r, sent_n;
  logic               err_r, err_n;
  logic               clk_meta_r, clk_sync_r, clk_prev_r;
  logic               dat_meta_r, dat_sync_r;
  logic               clk_fall_s;

  // Synchronise the raw pins; idle-high reset values avoid a false edge after reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk_in;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= ps2_dat_in;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign clk_fall_s = clk_prev_r & ~clk_sync_r;

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= 4'd0;
      cmd_r     <= 8'd0;
      par_r     <= 1'b0;
      clk_oe_r  <= 1'b0;
      dat_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      sent_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_cnt_r <= bit_cnt_n;
      cmd_r     <= cmd_n;
      par_r     <= par_n;
      clk_oe_r  <= clk_oe_n;
      dat_oe_r  <= dat_oe_n;
      busy_r    <= busy_n;
      sent_r    <= sent_n;
      err_r     <= err_n;
    end
  end

  // Next-state logic; the data line only changes on a detected clock fall.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_cnt_n = bit_cnt_r;
    cmd_n     = cmd_r;
    par_n     = par_r;
    dat_oe_n  = dat_oe_r;
    case (state_r)
      ST_IDLE: begin
        cnt_n     = {CNT_W{1'b0}};
        bit_cnt_n = 4'd0;
        if (cmd_if.send_command) begin
          cmd_n   = cmd_if.command;
          par_n   = odd_parity(cmd_if.command);
          state_n = ST_INHIBIT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (cnt_r >= CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_n    = {CNT_W{1'b0}};
          dat_oe_n = 1'b1;
          state_n  = ST_REQUEST;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_REQUEST: begin
        cnt_n    = {CNT_W{1'b0}};
        dat_oe_n = 1'b1;
        state_n  = ST_WAIT_CLK;
      end
      ST_WAIT_CLK: begin
        if (clk_fall_s) begin
          dat_oe_n  = ~cmd_r[0];
          bit_cnt_n = 4'd1;
          cnt_n     = {CNT_W{1'b0}};
          state_n   = ST_SEND;
        end else if (cnt_r >= CNT_W'(START_TIMEOUT)) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (cnt_r >= CNT_W'(XFER_TIMEOUT)) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
          if (clk_fall_s) begin
            bit_cnt_n = bit_cnt_inc(bit_cnt_r);
            if (bit_cnt_r < 4'd8) begin
              dat_oe_n = ~cmd_r[bit_cnt_r[2:0]];
            end else if (bit_cnt_r == 4'd8) begin
              dat_oe_n = ~par_r;
            end else begin
              dat_oe_n = 1'b0;
              state_n  = ST_WAIT_ACK;
            end
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (cnt_r >= CNT_W'(XFER_TIMEOUT)) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
          if (clk_fall_s) begin
            bit_cnt_n = bit_cnt_inc(bit_cnt_r);
            state_n   = dat_sync_r ? ST_ERROR : ST_WAIT_RELEASE;
          end else begin
            state_n = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (cnt_r >= CNT_W'(XFER_TIMEOUT)) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
          if (clk_sync_r && dat_sync_r) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT_RELEASE;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_ERROR: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // Outputs follow the next state so each one is a plain flop.
    clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_REQUEST);
    dat_oe_n = dat_oe_n && (state_n != ST_IDLE) && (state_n != ST_ERROR) && (state_n != ST_DONE)
               && (state_n != ST_INHIBIT);
    busy_n   = (state_n != ST_IDLE);
    sent_n   = (state_n == ST_DONE);
    err_n    = (state_n == ST_ERROR);
  end

  assign ps2_clk_oe                           = clk_oe_r;
  assign ps2_dat_oe                           = dat_oe_r;
  assign cmd_if.busy                          = busy_r;
  assign cmd_if.command_was_sent              = sent_r;
  assign cmd_if.error_communication_timed_out = err_r;

endmodule

// File: tb/tb_ps2_command_transmitter.sv
// Directed bench: an open-drain PS/2 device model clocks frames out of the transmitter
// and every observation is compared against hand-computed frames and timings.
module tb_ps2_command_transmitter;
  localparam int INH   = 50;
  localparam int ST_TO = 200;
  localparam int XF_TO = 1000;
  localparam int HALF  = 20;

  logic CLOCK_50 = 1'b0;
  logic resetn;
  logic dev_clk_low, dev_dat_low;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sent_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0, fall_cyc = 0;

  ps2_command_transmitter_if cmd_if();

  ps2_command_transmitter #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST_TO),
    .XFER_TIMEOUT   (XF_TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .cmd_if     (cmd_if),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (cmd_if.command_was_sent === 1'b1) sent_cnt++;
    if (cmd_if.error_communication_timed_out === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (cmd_if.command_was_sent === 1'b1 && cmd_if.error_communication_timed_out === 1'b1) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic start_send(input logic [7:0] value);
    cmd_if.command      = value;
    cmd_if.send_command = 1'b1;
    tick();
    cmd_if.send_command = 1'b0;
  endtask

  // Measures the inhibit phase and returns once the host releases the clock.
  task automatic host_phase(output int inh_len);
    int n;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 10) begin tick(); n++; end
    inh_len = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && inh_len < 10 * INH) begin tick(); inh_len++; end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 5) begin tick(); n++; end
  endtask

  // Device model: samples the line at each clock rise; the first sample is the
  // rise caused by the host releasing the clock (the start bit).
  task automatic device(input logic ack, input int inject_edge, input int abort_edge,
                        output logic [10:0] bits);
    bit stop;
    stop = 1'b0;
    bits = 11'd0;
    bits[0] = ps2_dat_in;
    for (int e = 1; e <= 11 && !stop; e++) begin
      repeat (HALF) tick();
      if (e == 11) begin
        dev_dat_low = ack;
        tick();
      end
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      if (e == abort_edge) begin
        stop = 1'b1;
      end else begin
        if (e == inject_edge) begin
          tick();
          tick();
          cmd_if.command      = 8'h55;
          cmd_if.send_command = 1'b1;
          tick();
          cmd_if.send_command = 1'b0;
        end
        repeat (HALF) tick();
        if (e <= 10) bits[e] = ps2_dat_in;
        dev_clk_low = 1'b0;
      end
    end
    if (!stop) begin
      tick();
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (cmd_if.command_was_sent !== 1'b1 && cmd_if.error_communication_timed_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] exp_frame;
    int inh_len, n, s0, e0, highs;

    resetn = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    cmd_if.command = 8'h00;
    cmd_if.send_command = 1'b0;
    repeat (3) tick();
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_busy", 32'(cmd_if.busy), 32'd0);
    check("rst_sent", 32'(cmd_if.command_was_sent), 32'd0);
    check("rst_err", 32'(cmd_if.error_communication_timed_out), 32'd0);
    resetn = 1'b1;
    repeat (3) tick();

    // 0xED with ACK: six ones, so the odd-parity bit is 1.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'hED);
    check("ed_busy", 32'(cmd_if.busy), 32'd1);
    host_phase(inh_len);
    check("ed_inhibit_len", 32'(inh_len), 32'(INH));
    device(1'b1, 0, 0, bits);
    exp_frame = {1'b1, 1'b1, 8'hED, 1'b0};
    check("ed_frame", 32'(bits), 32'(exp_frame));
    wait_pulse(n);
    check("ed_sent_pulse", 32'(cmd_if.command_was_sent), 32'd1);
    check("ed_busy_at_pulse", 32'(cmd_if.busy), 32'd1);
    tick();
    check("ed_busy_after", 32'(cmd_if.busy), 32'd0);
    check("ed_sent_cnt", 32'(sent_cnt - s0), 32'd1);
    check("ed_err_cnt", 32'(err_cnt - e0), 32'd0);
    repeat (5) tick();

    // 0x00: all data bits 0, parity 1.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'h00);
    host_phase(inh_len);
    device(1'b1, 0, 0, bits);
    exp_frame = {1'b1, 1'b1, 8'h00, 1'b0};
    check("z_frame", 32'(bits), 32'(exp_frame));
    wait_pulse(n);
    tick();
    check("z_sent_cnt", 32'(sent_cnt - s0), 32'd1);
    check("z_err_cnt", 32'(err_cnt - e0), 32'd0);
    repeat (5) tick();

    // Device never clocks: start timeout.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'hFF);
    host_phase(inh_len);
    n = 0;
    while (cmd_if.error_communication_timed_out !== 1'b1 && n < 2 * ST_TO) begin tick(); n++; end
    check("to_latency_in_range", 32'(n >= ST_TO && n <= ST_TO + 3), 32'd1);
    tick();
    check("to_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("to_busy_after", 32'(cmd_if.busy), 32'd0);
    check("to_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("to_sent_cnt", 32'(sent_cnt - s0), 32'd0);
    repeat (5) tick();

    // DAT held high at edge 11: missing ACK.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'hED);
    host_phase(inh_len);
    device(1'b0, 0, 0, bits);
    repeat (10) tick();
    check("nak_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("nak_err_latency", 32'((err_cyc - fall_cyc) >= 1 && (err_cyc - fall_cyc) <= 3), 32'd1);
    check("nak_sent_cnt", 32'(sent_cnt - s0), 32'd0);
    repeat (5) tick();

    // 0x55 request while 0xF4 is in flight must be dropped. 0xF4 has five ones, parity 0.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'hF4);
    host_phase(inh_len);
    device(1'b1, 3, 0, bits);
    exp_frame = {1'b1, 1'b0, 8'hF4, 1'b0};
    check("inj_frame", 32'(bits), 32'(exp_frame));
    wait_pulse(n);
    tick();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (ps2_clk_oe === 1'b1) highs++;
      tick();
    end
    check("inj_no_second_xfer", 32'(highs), 32'd0);
    check("inj_sent_cnt", 32'(sent_cnt - s0), 32'd1);
    check("inj_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Reset while bit 4 (a 0 for 0x0F) is on the line.
    start_send(8'h0F);
    host_phase(inh_len);
    device(1'b1, 0, 5, bits);
    repeat (4) tick();
    check("rs_dat_driven", 32'(ps2_dat_oe), 32'd1);
    s0 = sent_cnt; e0 = err_cnt;
    #3 resetn = 1'b0;
    #1;
    check("rs_oe_async", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("rs_busy", 32'(cmd_if.busy), 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    #3 resetn = 1'b1;
    repeat (5) tick();
    check("rs_no_pulses", 32'((sent_cnt - s0) + (err_cnt - e0)), 32'd0);

    // 0xFF after reset: eight ones, parity 1.
    s0 = sent_cnt; e0 = err_cnt;
    start_send(8'hFF);
    host_phase(inh_len);
    device(1'b1, 0, 0, bits);
    exp_frame = {1'b1, 1'b1, 8'hFF, 1'b0};
    check("ff_frame", 32'(bits), 32'(exp_frame));
    wait_pulse(n);
    tick();
    check("ff_sent_cnt", 32'(sent_cnt - s0), 32'd1);
    check("ff_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("no_coincident_pulses", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
